bcd_serial_adder: RTL and testbench

Digit-serial packed-BCD adder that consumes the 4-bit binary sum/carry stage and applies decimal correction, one BCD digit per clock, least significant digit first. It accepts two DIGITS-wide packed-BCD operands plus carry-in through a valid/ready request handshake. It returns the packed-BCD sum, the decimal carry-out and an invalid-digit flag through a valid/ready result handshake. It sits downstream of the 4-bit binary adder in the BCD datapath and lets wide decimal operands be summed with a single digit adder.

---
 rtl/bcd_serial_adder.sv | 123 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit corrected per clock, LSD first.
// Latency: accept at edge k, result valid from edge k+DIGITS (DIGITS cycles in RUN).
// Backpressure: result held in DONE until done_ready; requests only taken in IDLE.
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [4*DIGITS-1:0]   a_in,
   input  logic [4*DIGITS-1:0]   b_in,
   input  logic                  cin_in,
   output logic                  busy,
   output logic                  done_valid,
   input  logic                  done_ready,
   output logic [4*DIGITS-1:0]   sum_out,
   output logic                  cout_out,
   output logic                  invalid_out
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [W-1:0]    a_sh;
   logic [W-1:0]    b_sh;
   logic            carry;
   logic [IW-1:0]   idx;

   logic [3:0]      a_dig;
   logic [3:0]      b_dig;
   logic [4:0]      raw;
   logic [3:0]      dig;
   logic            carry_nxt;
   logic            dig_bad;
   logic            last_dig;
   logic [W-1:0]    sum_shift;

   // Per-digit binary sum with decimal correction; the +6 wraps mod 16 in 4 bits.
   always_comb begin
      a_dig     = a_sh[3:0];
      b_dig     = b_sh[3:0];
      raw       = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
      carry_nxt = (raw > 5'd9);
      dig       = carry_nxt ? (raw[3:0] + 4'd6) : raw[3:0];
      dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
      last_dig  = (idx == IW'(DIGITS - 1));
      sum_shift = sum_out >> 4;
      sum_shift[W-1 -: 4] = dig;
   end

   // State register; rst wins over every transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_valid) state_nxt = RUN;
         RUN:     if (last_dig)    state_nxt = DONE;
         DONE:    if (done_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, digit shifting and result accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh        <= '0;
         b_sh        <= '0;
         carry       <= 1'b0;
         idx         <= '0;
         sum_out     <= '0;
         cout_out    <= 1'b0;
         invalid_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_sh        <= a_in;
                  b_sh        <= b_in;
                  carry       <= cin_in;
                  idx         <= '0;
                  sum_out     <= '0;
                  cout_out    <= 1'b0;
                  invalid_out <= 1'b0;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> 4;
               b_sh    <= b_sh >> 4;
               carry   <= carry_nxt;
               idx     <= idx + IW'(1);
               sum_out <= sum_shift;
               if (dig_bad)  invalid_out <= 1'b1;
               if (last_dig) cout_out    <= carry_nxt;
            end
            default: ;
         endcase
      end
   end

   // Handshake and status flags decode straight from the registered state.
   assign start_ready = (state == IDLE);
   assign busy        = (state == RUN);
   assign done_valid  = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        cin_in;
   logic        busy;
   logic        done_valid;
   logic        done_ready;
   logic [15:0] sum_out;
   logic        cout_out;
   logic        invalid_out;

   int tests = 0;
   int fails = 0;

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a_in        (a_in),
      .b_in        (b_in),
      .cin_in      (cin_in),
      .busy        (busy),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .sum_out     (sum_out),
      .cout_out    (cout_out),
      .invalid_out (invalid_out)
   );

   always #5 clk = ~clk;

   // Reference model: decimal value of a packed-BCD word and back.
   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int n);
      logic [15:0] r = '0;
      int m = n;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] rand_bcd();
      logic [15:0] r;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(9));
      return r;
   endfunction

   // Drives one request and completes the result handshake; returns what was observed.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [15:0] s, output logic co, output logic inv,
                        output int lat);
      int w = 0;
      while (!start_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      if (!start_ready) begin
         tests++; fails++;
         $display("FAIL op_ready_timeout start_ready=%0b required 1", start_ready);
      end
      a_in = a; b_in = b; cin_in = c; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      lat = 0;
      while (!done_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      s = sum_out; co = cout_out; inv = invalid_out;
      done_ready = 1'b1;
      @(posedge clk); #1;
      done_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({start_ready, busy, done_valid, sum_out, cout_out, invalid_out} !== {3'b100, 16'h0, 2'b00}) begin
         fails++;
         $display("FAIL reset sr/busy/dv=%b%b%b sum=%h cout=%b inv=%b required 100 0000 0 0",
                  start_ready, busy, done_valid, sum_out, cout_out, invalid_out);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [15:0] av[5] = '{16'h1234, 16'h9999, 16'h9999, 16'h0000, 16'h0500};
      logic [15:0] bv[5] = '{16'h5678, 16'h0001, 16'h9999, 16'h0000, 16'h0500};
      logic        cv[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [15:0] s; logic co, inv; int lat, tot;
      for (int i = 0; i < 5; i++) begin
         do_op(av[i], bv[i], cv[i], s, co, inv, lat);
         tot = bcd2int(av[i]) + bcd2int(bv[i]) + int'(cv[i]);
         tests++;
         if ({s, co, inv} !== {int2bcd(tot % 10000), tot >= 10000, 1'b0} || lat != DIGITS) begin
            fails++;
            $display("FAIL directed_%0d %h+%h+%0b got sum=%h cout=%b inv=%b lat=%0d required sum=%h cout=%b inv=0 lat=%0d",
                     i, av[i], bv[i], cv[i], s, co, inv, lat, int2bcd(tot % 10000), tot >= 10000, DIGITS);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b, s; logic c, co, inv; int lat, tot;
      for (int i = 0; i < 40; i++) begin
         a = rand_bcd(); b = rand_bcd(); c = 1'($urandom_range(1));
         do_op(a, b, c, s, co, inv, lat);
         tot = bcd2int(a) + bcd2int(b) + int'(c);
         tests++;
         if ({s, co, inv} !== {int2bcd(tot % 10000), tot >= 10000, 1'b0} || lat != DIGITS) begin
            fails++;
            $display("FAIL random_%0d %h+%h+%0b got sum=%h cout=%b inv=%b lat=%0d required sum=%h cout=%b inv=0 lat=%0d",
                     i, a, b, c, s, co, inv, lat, int2bcd(tot % 10000), tot >= 10000, DIGITS);
         end
      end
   endtask

   task automatic test_invalid();
      logic [15:0] s; logic co, inv; int lat;
      // 0+5=5; A+0=10 -> 0 carry; 0+0+1=1; 0 -> 0x0105
      do_op(16'h00A0, 16'h0005, 1'b0, s, co, inv, lat);
      tests++;
      if ({s, co, inv} !== {16'h0105, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL invalid_flag got sum=%h cout=%b inv=%b required sum=0105 cout=0 inv=1", s, co, inv);
      end
      do_op(16'h0001, 16'h0001, 1'b0, s, co, inv, lat);
      tests++;
      if ({s, co, inv} !== {16'h0002, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL invalid_clear got sum=%h cout=%b inv=%b required sum=0002 cout=0 inv=0", s, co, inv);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_flags[7] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b100, 3'b010};
      a_in = 16'h0000; b_in = 16'h0000; cin_in = 1'b1;
      start_valid = 1'b1; done_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         tests++;
         if ({start_ready, busy, done_valid} !== exp_flags[c]) begin
            fails++;
            $display("FAIL b2b_cycle_%0d sr/busy/dv=%b%b%b required %b",
                     c + 1, start_ready, busy, done_valid, exp_flags[c]);
         end
         if (c == 4) begin
            tests++;
            if ({sum_out, cout_out} !== {16'h0001, 1'b0}) begin
               fails++;
               $display("FAIL b2b_result sum=%h cout=%b required 0001 0", sum_out, cout_out);
            end
         end
      end
      start_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      done_ready = 1'b0;
      tests++;
      if (start_ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_drain start_ready=%b required 1", start_ready);
      end
   endtask

   task automatic test_backpressure();
      int w = 0;
      a_in = 16'h1234; b_in = 16'h5678; cin_in = 1'b0; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      while (!done_valid && w < 50) begin
         @(posedge clk); #1; w++;
      end
      start_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         a_in = rand_bcd(); b_in = rand_bcd(); cin_in = 1'($urandom_range(1));
         @(posedge clk); #1;
         tests++;
         if ({done_valid, start_ready, sum_out, cout_out, invalid_out} !== {2'b10, 16'h6912, 2'b00}) begin
            fails++;
            $display("FAIL bp_hold_%0d dv=%b sr=%b sum=%h cout=%b inv=%b required dv=1 sr=0 sum=6912 cout=0 inv=0",
                     c, done_valid, start_ready, sum_out, cout_out, invalid_out);
         end
      end
      start_valid = 1'b0; done_ready = 1'b1;
      @(posedge clk); #1;
      done_ready = 1'b0;
      tests++;
      if ({start_ready, done_valid, sum_out} !== {2'b10, 16'h6912}) begin
         fails++;
         $display("FAIL bp_release sr=%b dv=%b sum=%h required sr=1 dv=0 sum=6912",
                  start_ready, done_valid, sum_out);
      end
   endtask

   task automatic test_midrun_reset();
      logic [15:0] s; logic co, inv; int lat;
      a_in = 16'h432A; b_in = 16'h1111; cin_in = 1'b0; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests++;
      if ({start_ready, busy, done_valid, sum_out, cout_out, invalid_out} !== {3'b100, 16'h0, 2'b00}) begin
         fails++;
         $display("FAIL midrun_reset sr/busy/dv=%b%b%b sum=%h cout=%b inv=%b required 100 0000 0 0",
                  start_ready, busy, done_valid, sum_out, cout_out, invalid_out);
      end
      do_op(16'h0500, 16'h0500, 1'b0, s, co, inv, lat);
      tests++;
      if ({s, co, inv} !== {16'h1000, 1'b0, 1'b0} || lat != DIGITS) begin
         fails++;
         $display("FAIL post_reset_op sum=%h cout=%b inv=%b lat=%0d required 1000 0 0 lat=%0d",
                  s, co, inv, lat, DIGITS);
      end
   endtask

   initial begin
      rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
      a_in = '0; b_in = '0; cin_in = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_invalid();
      test_back_to_back();
      test_backpressure();
      test_midrun_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
